// File: rtl/linebuf_pkg.sv
// linebuf_pkg: shared FSM state encoding and default geometry for the line-buffer controller.
package linebuf_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_t;
  localparam int DEF_IMG_W = 800;
  localparam int DEF_IMG_H = 480;
  localparam int DEF_WIN   = 3;
  localparam int DEF_DW    = 8;
endpackage

// File: rtl/edge_det.sv
// edge_det: rise/fall of a 1-bit signal, detected against its registered copy.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);
  logic r_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_q <= 1'b0;
    else     r_q <= i_sig;
  assign o_rise = i_sig & ~r_q;
  assign o_fall = ~i_sig & r_q;
endmodule

// File: rtl/linebuf_ctrl.sv
// linebuf_ctrl: line-buffer write/read sequencing, pixel coordinates and window-valid flag.
// Define LINEBUF_CTRL_ERR_EN to flag wrong-length lines and park the FSM in HOLD.
module linebuf_ctrl
  import linebuf_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int WIN   = DEF_WIN,
  parameter int DW    = DEF_DW
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          vs_i,
  input  logic                          de_i,
  input  logic [DW-1:0]                 pix_i,
  output logic                          buf_wr_en,
  output logic                          buf_rd_en,
  output logic [DW-1:0]                 pix_o,
  output logic [$clog2(IMG_W+1)-1:0]    col_o,
  output logic [$clog2(IMG_H+1)-1:0]    row_o,
  output logic                          win_valid,
  output logic                          frame_done,
  output logic                          err_o,
  output logic [1:0]                    state_o
);
  localparam int R  = (WIN - 1) / 2;
  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);
  localparam logic [CW-1:0] C_MAX  = CW'(IMG_W);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] C_2R   = CW'(2 * R);
  localparam logic [RW-1:0] R_H    = RW'(IMG_H);
  localparam logic [RW-1:0] R_2R   = RW'(2 * R);

  state_t          r_state, w_state_nx;
  logic [CW-1:0]   r_col, w_col_nx;
  logic [RW-1:0]   r_row, w_row_nx;
  logic [DW-1:0]   r_pix;
  logic            r_wr, r_win, r_done, r_err;
  logic            w_vs_rise, w_unused_vs_fall, w_de_rise, w_de_fall;
  logic            w_active, w_len_err, w_wr_nx, w_win_nx, w_done_nx;

  edge_det u_vs (.clk(clk), .rst(rst), .i_sig(vs_i), .o_rise(w_vs_rise), .o_fall(w_unused_vs_fall));
  edge_det u_de (.clk(clk), .rst(rst), .i_sig(de_i), .o_rise(w_de_rise), .o_fall(w_de_fall));

  assign w_active = (r_state == FILL) || (r_state == RUN);

  // A vs rise overrides everything, including a coincident end-of-line row increment.
  always_comb begin
    w_col_nx = w_vs_rise ? '0 :
               !w_active ? r_col :
               (w_de_fall || w_de_rise) ? '0 :
               !de_i ? r_col :
               (r_col == C_MAX) ? r_col : r_col + 1'b1;
    w_row_nx = w_vs_rise ? '0 : (w_active && w_de_fall) ? r_row + 1'b1 : r_row;
  end

`ifdef LINEBUF_CTRL_ERR_EN
  // col holds the last pixel's index at the fall, so a correct line ends on IMG_W-1.
  assign w_len_err = w_active && w_de_fall && (r_col != C_LAST);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_err <= 1'b0;
    else     r_err <= !w_vs_rise && (r_err || w_len_err);
`else
  assign w_len_err = 1'b0;
  assign r_err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;

  always_comb begin
    w_state_nx = w_vs_rise ? FILL :
                 w_len_err ? HOLD :
                 (r_state == FILL && w_de_fall && w_row_nx == R_2R) ? RUN :
                 (r_state == RUN  && w_de_fall && w_row_nx == R_H)  ? IDLE : r_state;
  end

  always_comb begin
    w_wr_nx   = de_i && (w_state_nx == FILL || w_state_nx == RUN);
    w_win_nx  = (w_state_nx == RUN) && de_i && (w_col_nx >= C_2R) && (w_row_nx >= R_2R);
    w_done_nx = (r_state == RUN) && (w_state_nx == IDLE);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_col  <= '0;
      r_row  <= '0;
      r_pix  <= '0;
      r_wr   <= 1'b0;
      r_win  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_col  <= w_col_nx;
      r_row  <= w_row_nx;
      r_pix  <= pix_i;
      r_wr   <= w_wr_nx;
      r_win  <= w_win_nx;
      r_done <= w_done_nx;
    end

  assign buf_wr_en  = r_wr;
  assign buf_rd_en  = r_wr;
  assign pix_o      = r_pix;
  assign col_o      = r_col;
  assign row_o      = r_row;
  assign win_valid  = r_win;
  assign frame_done = r_done;
  assign err_o      = r_err;
  assign state_o    = r_state;
endmodule

// File: tb/tb_linebuf_ctrl.sv
// tb_linebuf_ctrl: table vectors plus hand-written frame sequences for linebuf_ctrl (IMG_W=8, IMG_H=6, WIN=3).
module tb_linebuf_ctrl;
  localparam int W = 8;

  logic       clk = 1'b0, rst = 1'b1, vs_i = 1'b0, de_i = 1'b0;
  logic [7:0] pix_i = '0;
  logic       buf_wr_en, buf_rd_en, win_valid, frame_done, err_o;
  logic [7:0] pix_o;
  logic [3:0] col_o;
  logic [2:0] row_o;
  logic [1:0] state_o;

  linebuf_ctrl #(.IMG_W(8), .IMG_H(6), .WIN(3), .DW(8)) dut (
    .clk(clk), .rst(rst), .vs_i(vs_i), .de_i(de_i), .pix_i(pix_i),
    .buf_wr_en(buf_wr_en), .buf_rd_en(buf_rd_en), .pix_o(pix_o),
    .col_o(col_o), .row_o(row_o), .win_valid(win_valid),
    .frame_done(frame_done), .err_o(err_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit vs; bit de; logic [7:0] px;
    int wr; int st; int col; int row; int win; int done;
  } vec_t;

  vec_t       tbl [15];
  logic [7:0] pq [$];
  int n_cmp = 0, n_bad = 0, cnt_wr = 0, cnt_win = 0, cnt_done = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, want %0d", nm, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit vs, input bit de, input logic [7:0] px,
                              input int wr, input int st, input int col, input int row,
                              input int win, input int done);
    vec_t v;
    v.vs = vs; v.de = de; v.px = px; v.wr = wr; v.st = st;
    v.col = col; v.row = row; v.win = win; v.done = done;
    return v;
  endfunction

  // One clock: drive at negedge, queue the expected pixel, check it 1 ns after the edge.
  task automatic drive(input bit vs, input bit de, input logic [7:0] px);
    logic [7:0] e;
    @(negedge clk);
    vs_i = vs; de_i = de; pix_i = px;
    pq.push_back(px);
    @(posedge clk); #1;
    e = pq.pop_front();
    chk("pix_o", int'(pix_o), int'(e));
    cnt_wr   += int'(buf_wr_en);
    cnt_win  += int'(win_valid);
    cnt_done += int'(frame_done);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr"}, int'(buf_wr_en), 0);
    chk({tag, "_rd"}, int'(buf_rd_en), 0);
    chk({tag, "_pix"}, int'(pix_o), 0);
    chk({tag, "_col"}, int'(col_o), 0);
    chk({tag, "_row"}, int'(row_o), 0);
    chk({tag, "_win"}, int'(win_valid), 0);
    chk({tag, "_done"}, int'(frame_done), 0);
    chk({tag, "_err"}, int'(err_o), 0);
    chk({tag, "_state"}, int'(state_o), 0);
  endtask

  task automatic line(input int ln, input int n, input bit run);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, 8'($urandom));
      chk("line_col", int'(col_o), (i >= W) ? W : i);
      chk("line_row", int'(row_o), ln);
      chk("line_wr", int'(buf_wr_en), 1);
      chk("line_rd", int'(buf_rd_en), 1);
      chk("line_win", int'(win_valid), (run && i >= 2) ? 1 : 0);
    end
    drive(1'b0, 1'b0, 8'h00);
    chk("eol_row", int'(row_o), ln + 1);
    chk("eol_col", int'(col_o), 0);
    chk("eol_wr", int'(buf_wr_en), 0);
    chk("eol_win", int'(win_valid), 0);
  endtask

  initial begin
    tbl[0] = mk(0, 1, 8'h11, 0, 0, 0, 0, 0, 0);
    tbl[1] = mk(0, 0, 8'h12, 0, 0, 0, 0, 0, 0);
    tbl[2] = mk(1, 0, 8'h22, 0, 1, 0, 0, 0, 0);
    tbl[3] = mk(1, 0, 8'h23, 0, 1, 0, 0, 0, 0);
    tbl[4] = mk(0, 0, 8'h24, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) tbl[5+i] = mk(0, 1, 8'(8'h30 + i), 1, 1, i, 0, 0, 0);
    tbl[13] = mk(0, 0, 8'h40, 0, 1, 0, 1, 0, 0);
    tbl[14] = mk(0, 0, 8'h41, 0, 1, 0, 1, 0, 0);

    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk) rst = 1'b0;

    foreach (tbl[k]) begin
      drive(tbl[k].vs, tbl[k].de, tbl[k].px);
      chk("tbl_wr", int'(buf_wr_en), tbl[k].wr);
      chk("tbl_rd", int'(buf_rd_en), tbl[k].wr);
      chk("tbl_state", int'(state_o), tbl[k].st);
      chk("tbl_col", int'(col_o), tbl[k].col);
      chk("tbl_row", int'(row_o), tbl[k].row);
      chk("tbl_win", int'(win_valid), tbl[k].win);
      chk("tbl_done", int'(frame_done), tbl[k].done);
    end

    // full frame, restarting from the FILL frame left by the table
    drive(1'b1, 1'b0, 8'h00);
    chk("ff_state", int'(state_o), 1);
    chk("ff_row", int'(row_o), 0);
    drive(1'b0, 1'b0, 8'h00);
    cnt_wr = 0; cnt_win = 0; cnt_done = 0;
    line(0, 8, 1'b0);
    chk("fill0_state", int'(state_o), 1);
    line(1, 8, 1'b0);
    chk("fill_wr_cnt", cnt_wr, 16);
    chk("fill_win_cnt", cnt_win, 0);
    chk("run_state", int'(state_o), 2);
    for (int l = 2; l < 6; l++) line(l, 8, 1'b1);
    chk("done_pulse", int'(frame_done), 1);
    chk("end_state", int'(state_o), 0);
    drive(1'b0, 1'b0, 8'h00);
    chk("done_clear", int'(frame_done), 0);
    chk("win_total", cnt_win, 24);
    chk("done_total", cnt_done, 1);
    drive(1'b0, 1'b1, 8'h77);
    chk("idle_de_wr", int'(buf_wr_en), 0);
    chk("idle_de_col", int'(col_o), 0);
    drive(1'b0, 1'b0, 8'h00);
    chk("idle_row", int'(row_o), 6);

    // vs rise in the middle of row 3
    cnt_done = 0;
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    line(0, 8, 1'b0); line(1, 8, 1'b0); line(2, 8, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 8'($urandom));
      chk("mid_row", int'(row_o), 3);
      chk("mid_win", int'(win_valid), (i >= 2) ? 1 : 0);
    end
    drive(1'b1, 1'b1, 8'h5a);
    chk("mvs_row", int'(row_o), 0);
    chk("mvs_col", int'(col_o), 0);
    chk("mvs_state", int'(state_o), 1);
    chk("mvs_wr", int'(buf_wr_en), 1);
    chk("mvs_win", int'(win_valid), 0);
    for (int i = 1; i < 8; i++) begin
      drive(1'b0, 1'b1, 8'($urandom));
      chk("mvs_col_run", int'(col_o), i);
      chk("mvs_state_run", int'(state_o), 1);
    end
    drive(1'b0, 1'b0, 8'h00);
    chk("mvs_row_end", int'(row_o), 1);
    chk("mvs_no_done", cnt_done, 0);

    // vs rise coincident with de fall: the row increment is dropped
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 8'($urandom));
    drive(1'b1, 1'b0, 8'h00);
    chk("sim_row", int'(row_o), 0);
    chk("sim_state", int'(state_o), 1);
    chk("sim_col", int'(col_o), 0);
    drive(1'b0, 1'b0, 8'h00);

`ifdef LINEBUF_CTRL_ERR_EN
    line(0, 8, 1'b0); line(1, 8, 1'b0); line(2, 7, 1'b1);
    chk("err_set", int'(err_o), 1);
    chk("err_state", int'(state_o), 3);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 8'($urandom));
      chk("hold_wr", int'(buf_wr_en), 0);
      chk("hold_col", int'(col_o), 0);
    end
    drive(1'b0, 1'b0, 8'h00);
    chk("hold_row", int'(row_o), 3);
    chk("hold_state", int'(state_o), 3);
    drive(1'b1, 1'b0, 8'h00);
    chk("err_clear", int'(err_o), 0);
    chk("err_restart", int'(state_o), 1);
    drive(1'b0, 1'b0, 8'h00);
`else
    line(0, 8, 1'b0); line(1, 8, 1'b0); line(2, 7, 1'b1);
    chk("short_err", int'(err_o), 0);
    chk("short_state", int'(state_o), 2);
    line(3, 10, 1'b1);
    chk("long_err", int'(err_o), 0);
    chk("long_state", int'(state_o), 2);
    drive(1'b1, 1'b0, 8'h00);
    chk("restart_state", int'(state_o), 1);
    drive(1'b0, 1'b0, 8'h00);
`endif

    // asynchronous reset between clock edges, mid-line
    line(0, 8, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 8'(8'hc0 + i));
    #3 rst = 1'b1;
    #1 chk_zero("arst");
    @(posedge clk); #1 chk_zero("arst_hold");
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 8'($urandom));
      chk("post_rst_wr", int'(buf_wr_en), 0);
      chk("post_rst_state", int'(state_o), 0);
    end
    drive(1'b0, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
